// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-path widths and sequencer state encoding.
package rv_pkg;
    localparam int INSTRSZ = 32;
    localparam int ADDRSZ = 64;
    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: memory fetch port, redirect input and decoder handshake.
interface fetch_sequencer_if #(
    parameter int INSTRSZ = rv_pkg::INSTRSZ,
    parameter int ADDRSZ = rv_pkg::ADDRSZ
);
    logic mem_req_valid;
    logic mem_req_ready;
    logic [ADDRSZ-1:0] mem_req_addr;
    logic mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic redirect_valid;
    logic [ADDRSZ-1:0] redirect_pc;
    logic inst_valid;
    logic inst_ready;
    logic [INSTRSZ-1:0] inst_data;
    logic [ADDRSZ-1:0] inst_pc;
    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
        input mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fifo.sv
// inst_fifo: instruction queue accepting up to two entries per cycle, with flush.
module inst_fifo #(
    parameter int W = 96,
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic reset,
    input logic flush,
    input logic [1:0] push_n,
    input logic [W-1:0] d0,
    input logic [W-1:0] d1,
    input logic pop,
    output logic [W-1:0] head,
    output logic [CW-1:0] count,
    output logic empty,
    output logic full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    assign head = mem[rd];
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else if (flush) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            wr <= wr + AW'(push_n);
            rd <= rd + AW'(pop);
            count <= count + CW'(push_n) - CW'(pop);
        end
    end
    // d0 always lands first; d1 only when both words of a line are kept
    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0) mem[wr] <= d0;
        if (!flush && push_n == 2'd2) mem[wr + AW'(1)] <= d1;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 8-byte lines, splits them into instructions and
// queues them for the decoder, flushing and refetching on redirects.
module fetch_sequencer #(
    parameter int INSTRSZ = rv_pkg::INSTRSZ,
    parameter int ADDRSZ = rv_pkg::ADDRSZ,
    parameter logic [ADDRSZ-1:0] RESET_PC = '0,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    fetch_sequencer_if.master bus
);
    import rv_pkg::*;
    localparam int W = ADDRSZ + INSTRSZ;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - 2);
    fetch_state_t state;
    logic [ADDRSZ-1:0] fetch_pc, req_addr, line_addr, hi_pc;
    logic req_valid, accept, resp, room, pop, empty, full, unused_bits;
    logic [1:0] push_n;
    logic [CW-1:0] count;
    logic [W-1:0] d0, d1, head;
    assign line_addr = {fetch_pc[ADDRSZ-1:3], 3'b000};
    assign hi_pc = {fetch_pc[ADDRSZ-1:3], 3'b100};
    assign accept = req_valid && bus.mem_req_ready;
    assign resp = state == WAIT && bus.mem_resp_valid && !bus.redirect_valid;
    assign room = !full && count <= ROOM_MAX;
    assign pop = !empty && bus.inst_ready;
    // an odd-word fetch_pc keeps only the high half of the line
    assign push_n = resp ? (fetch_pc[2] ? 2'd1 : 2'd2) : 2'd0;
    assign d0 = fetch_pc[2] ? {hi_pc, bus.mem_resp_data[32 +: INSTRSZ]} : {line_addr, bus.mem_resp_data[INSTRSZ-1:0]};
    assign d1 = {hi_pc, bus.mem_resp_data[32 +: INSTRSZ]};
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr = req_addr;
    assign bus.inst_valid = !empty;
    assign {bus.inst_pc, bus.inst_data} = empty ? '0 : head;
    assign unused_bits = ^{fetch_pc[1:0], bus.redirect_pc[1:0]};
    inst_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(bus.redirect_valid),
        .push_n(push_n),
        .d0(d0),
        .d1(d1),
        .pop(pop),
        .head(head),
        .count(count),
        .empty(empty),
        .full(full)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            fetch_pc <= RESET_PC;
            req_valid <= 1'b0;
            req_addr <= '0;
        end else begin
            if (accept) req_valid <= 1'b0;
            else if (state == FETCH && !req_valid && !bus.redirect_valid && room) begin
                req_valid <= 1'b1;
                req_addr <= line_addr;
            end
            if (bus.redirect_valid) fetch_pc <= {bus.redirect_pc[ADDRSZ-1:2], 2'b00};
            else if (resp) fetch_pc <= line_addr + ADDRSZ'(8);
            // DRAIN waits for the stale request (if still pending) and swallows its response
            case (state)
                FETCH: state <= (req_valid && bus.redirect_valid) ? DRAIN : accept ? WAIT : FETCH;
                WAIT: state <= bus.mem_resp_valid ? FETCH : bus.redirect_valid ? DRAIN : WAIT;
                DRAIN: state <= (!req_valid && bus.mem_resp_valid) ? FETCH : DRAIN;
                default: state <= FETCH;
            endcase
        end
    end
endmodule
